// File: rtl/draw_pkg.sv
// Shared types and constants for the VGA draw path: screen bounds, field
// widths, the packed pixel record and an on-screen test used by clipping.
package draw_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COORD_W  = 15;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 9;

  // 24-bit pixel record; {x, y} matches the requester coords packing.
  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  function automatic logic pix_on_screen(input pixel_t p);
    return (int'(p.x) < SCREEN_W) && (int'(p.y) < SCREEN_H);
  endfunction

endpackage

// File: rtl/draw_pixel_fifo.sv
// Synchronous pixel FIFO. DEPTH must be a power of two so pointers wrap
// naturally. Push while full and pop while empty are ignored.
module draw_pixel_fifo
  import draw_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  pixel_t                   din,
  output pixel_t                   dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  pixel_t         r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           w_do_push;
  logic           w_do_pop;

  assign full      = (r_count == (AW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Storage array; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // Read/write pointers and occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Round-robin merge of drawing requesters into the single VGA write port.
// A combinational arbiter grants one requester per cycle into a pixel FIFO;
// a registered output stage drains it, one pixel per cycle, unless stalled.
// Optional macro DRAW_ARB_CLIP_EN: off-screen pixels are popped and dropped.
module vga_draw_arbiter
  import draw_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [COORD_W*NUM_REQ-1:0]      req_coords,
  input  logic [COLOUR_W*NUM_REQ-1:0]     req_colour,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            vga_stall,
  output logic [X_W-1:0]                  vga_x,
  output logic [Y_W-1:0]                  vga_y,
  output logic [COLOUR_W-1:0]             vga_colour,
  output logic                            vga_plot,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            idle
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]          r_rr_ptr;
  logic [PW-1:0]          w_grant_idx;
  logic                   w_grant_any;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_keep;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  pixel_t                 w_push_px;
  pixel_t                 w_pop_px;
  logic [X_W-1:0]         r_x;
  logic [Y_W-1:0]         r_y;
  logic [COLOUR_W-1:0]    r_colour;
  logic                   r_plot;

  // Search for the first valid requester starting at the round-robin pointer.
  always_comb begin
    int            w_idx;
    logic [PW-1:0] w_cand;
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_idx       = 0;
    w_cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx  = (int'(r_rr_ptr) + k) % NUM_REQ;
      w_cand = PW'(w_idx);
      if (!w_grant_any && req_valid[w_cand]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  // One-hot ready; a full FIFO blocks all grants even if a pop is underway.
  always_comb begin
    req_ready = '0;
    if (w_grant_any && !w_fifo_full) req_ready[w_grant_idx] = 1'b1;
  end

  assign w_push    = w_grant_any && !w_fifo_full;
  assign w_push_px = {req_coords[w_grant_idx*COORD_W +: COORD_W],
                      req_colour[w_grant_idx*COLOUR_W +: COLOUR_W]};
  assign w_pop     = !w_fifo_empty && !vga_stall;

`ifdef DRAW_ARB_CLIP_EN
  assign w_keep = pix_on_screen(w_pop_px);
`else
  assign w_keep = 1'b1;
`endif

  // Advance the round-robin pointer past the requester just served.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rr_ptr <= '0;
    end else if (w_push) begin
      r_rr_ptr <= PW'((int'(w_grant_idx) + 1) % NUM_REQ);
    end
  end

  draw_pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (w_push),
    .pop    (w_pop),
    .din    (w_push_px),
    .dout   (w_pop_px),
    .count  (fifo_count),
    .full   (w_fifo_full),
    .empty  (w_fifo_empty)
  );

  // Output register: plot pulses once per forwarded pixel, coords hold otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
      r_plot   <= 1'b0;
    end else begin
      r_plot <= 1'b0;
      if (w_pop && w_keep) begin
        r_x      <= w_pop_px.x;
        r_y      <= w_pop_px.y;
        r_colour <= w_pop_px.colour;
        r_plot   <= 1'b1;
      end
    end
  end

  assign vga_x      = r_x;
  assign vga_y      = r_y;
  assign vga_colour = r_colour;
  assign vga_plot   = r_plot;
  assign idle       = w_fifo_empty && !r_plot;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed bench for vga_draw_arbiter (NUM_REQ=4, FIFO_DEPTH=8).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_vga_draw_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  req_valid;
  logic [59:0] req_coords;
  logic [35:0] req_colour;
  logic [3:0]  req_ready;
  logic        vga_stall;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [8:0]  vga_colour;
  logic        vga_plot;
  logic [3:0]  fifo_count;
  logic        idle;

  int n_checks = 0;
  int n_errors = 0;

  vga_draw_arbiter #(
    .NUM_REQ    (4),
    .FIFO_DEPTH (8)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_coords (req_coords),
    .req_colour (req_colour),
    .req_ready  (req_ready),
    .vga_stall  (vga_stall),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .fifo_count (fifo_count),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [7:0] x, input logic [6:0] y, input logic [8:0] c);
    req_coords[15*i +: 15] = {x, y};
    req_colour[9*i +: 9]   = c;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
  endtask

  initial begin
    int ghost;
    int nplot;
    int first_x;
    int last_x;

    resetn     = 1'b0;
    vga_stall  = 1'b0;
    req_valid  = '0;
    req_coords = '0;
    req_colour = '0;

    // Reset state
    @(negedge clk);
    check("rst_plot", vga_plot, 0);
    check("rst_count", fifo_count, 0);
    check("rst_idle", idle, 1);
    check("rst_x", vga_x, 0);
    check("rst_colour", vga_colour, 0);
    resetn = 1'b1;

    // Single request, two-edge latency
    set_req(0, 8'd20, 7'd30, 9'h007);
    req_valid = 4'b0001;
    #1 check("t1_ready", req_ready, 4'b0001);
    step();
    req_valid = '0;
    #1;
    check("t1_count", fifo_count, 1);
    check("t1_plot_early", vga_plot, 0);
    check("t1_idle_busy", idle, 0);
    step();
    #1;
    check("t1_plot", vga_plot, 1);
    check("t1_x", vga_x, 20);
    check("t1_y", vga_y, 30);
    check("t1_colour", vga_colour, 9'h007);
    step();
    #1;
    check("t1_plot_off", vga_plot, 0);
    check("t1_idle", idle, 1);

    // All four valid: round robin 0,1,2,3,0,1,2,3
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) set_req(i, 8'(40 + i), 7'(i), 9'(9'h010 + i));
    for (int c = 0; c < 10; c++) begin
      req_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      if (c < 8) check("t2_ready", req_ready, 32'(1 << (c % 4)));
      if (c >= 2) begin
        check("t2_plot", vga_plot, 1);
        check("t2_x", vga_x, 40 + ((c - 2) % 4));
        check("t2_colour", vga_colour, 9'h010 + ((c - 2) % 4));
      end else begin
        check("t2_plot_early", vga_plot, 0);
      end
      step();
    end
    #1;
    check("t2_plot_off", vga_plot, 0);
    check("t2_idle", idle, 1);

    // Stall: fill to 8, ready drops, then drain in order
    vga_stall = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set_req(2, 8'(100 + k), 7'(k), 9'(9'h100 + k));
      req_valid = 4'b0100;
      #1;
      check("t3_ready", req_ready, 4'b0100);
      check("t3_plot_stalled", vga_plot, 0);
      step();
    end
    set_req(2, 8'd200, 7'd0, 9'h000);
    #1;
    check("t3_count_full", fifo_count, 8);
    check("t3_ready_full", req_ready, 0);
    step();
    #1;
    check("t3_count_hold", fifo_count, 8);
    vga_stall = 1'b0;
    req_valid = '0;
    step();
    for (int k = 0; k < 8; k++) begin
      #1;
      check("t3_plot", vga_plot, 1);
      check("t3_x", vga_x, 100 + k);
      check("t3_y", vga_y, k);
      check("t3_colour", vga_colour, 9'h100 + k);
      check("t3_count", fifo_count, 7 - k);
      step();
    end
    #1;
    check("t3_plot_off", vga_plot, 0);
    check("t3_count_empty", fifo_count, 0);
    check("t3_idle", idle, 1);
    step();

    // Seven queued, then simultaneous push and pop
    vga_stall = 1'b1;
    for (int k = 0; k < 7; k++) begin
      set_req(1, 8'(60 + k), 7'd5, 9'(9'h050 + k));
      req_valid = 4'b0010;
      #1 check("t4_ready", req_ready, 4'b0010);
      step();
    end
    #1 check("t4_count7", fifo_count, 7);
    vga_stall = 1'b0;
    set_req(1, 8'd67, 7'd5, 9'h057);
    #1 check("t4_ready_pp", req_ready, 4'b0010);
    step();
    req_valid = '0;
    #1;
    check("t4_count_pp", fifo_count, 7);
    check("t4_plot", vga_plot, 1);
    check("t4_x0", vga_x, 60);
    for (int k = 1; k < 8; k++) begin
      step();
      #1;
      check("t4_x", vga_x, 60 + k);
      check("t4_colour", vga_colour, 9'h050 + k);
      check("t4_count", fifo_count, 7 - k);
    end
    step();
    #1 check("t4_drained", fifo_count, 0);
    step();

    // Async reset mid-burst
    vga_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_req(3, 8'(80 + k), 7'd9, 9'h0f0);
      req_valid = 4'b1000;
      step();
    end
    vga_stall = 1'b0;
    req_valid = '0;
    step();
    #1;
    check("t5_plot_pre", vga_plot, 1);
    check("t5_x_pre", vga_x, 80);
    resetn = 1'b0;
    #1;
    check("t5_plot_async", vga_plot, 0);
    check("t5_count_async", fifo_count, 0);
    check("t5_idle_async", idle, 1);
    step();
    resetn = 1'b1;
    ghost = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      #1;
      if (vga_plot) ghost++;
    end
    check("t5_no_ghost", ghost, 0);
    check("t5_count", fifo_count, 0);
    step();

    // Off-screen entry followed by an on-screen one
    set_req(0, 8'd170, 7'd10, 9'h1ff);
    req_valid = 4'b0001;
    #1 check("t6_ready_a", req_ready, 4'b0001);
    step();
    set_req(0, 8'd5, 7'd10, 9'h0aa);
    #1 check("t6_ready_b", req_ready, 4'b0001);
    step();
    req_valid = '0;
    nplot   = 0;
    first_x = -1;
    last_x  = -1;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (vga_plot) begin
        if (nplot == 0) first_x = int'(vga_x);
        last_x = int'(vga_x);
        nplot++;
      end
      step();
    end
`ifdef DRAW_ARB_CLIP_EN
    check("t6_nplot", nplot, 1);
    check("t6_first_x", first_x, 5);
`else
    check("t6_nplot", nplot, 2);
    check("t6_first_x", first_x, 170);
`endif
    check("t6_last_x", last_x, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
